// File: rtl/keypad_entry.sv
// Keypad entry stage: synchronises and debounces scanner keys, assembles two decimal
// operands plus an operator, and hands them downstream over req/ack. Macro: ENTRY_BACKSPACE_EN.
module keypad_entry #(
    parameter int W          = 14,
    parameter int MAX_DIGITS = 4,
    parameter int DEB_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   key_code,
    input  logic         key_valid,
    input  logic         ack,
    output logic         req,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   op_code,
    output logic [W-1:0] disp_val,
    output logic         key_evt,
    output logic [3:0]   key_last
);
    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_DIGITS);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

    if ((10 ** MAX_DIGITS) - 1 >= (2 ** W)) begin : g_width_check
        $error("keypad_entry: W too narrow to hold MAX_DIGITS decimal digits");
    end

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_REQ = 2'd2
    } state_t;

    function automatic logic [W-1:0] append_digit(input logic [W-1:0] v, input logic [3:0] d);
        logic [W+3:0] t;
        t = ({4'b0000, v} << 2'd3) + ({4'b0000, v} << 1'b1) + {{W{1'b0}}, d};
        return t[W-1:0];
    endfunction

`ifdef ENTRY_BACKSPACE_EN
    function automatic logic [W-1:0] drop_digit(input logic [W-1:0] v);
        return v / W'(4'd10);
    endfunction
`endif

    logic           key_valid_s1_r, key_valid_s2_r;
    logic [3:0]     key_code_s1_r, key_code_s2_r;
    logic           deb_r, deb_nxt_s;
    logic [DCW-1:0] deb_cnt_r, deb_cnt_nxt_s;
    logic           press_s;
    logic           key_evt_r;
    logic [3:0]     key_last_r;

    state_t         state_r, state_nxt_s;
    logic [W-1:0]   a_r, a_nxt_s, b_r, b_nxt_s, disp_r, disp_nxt_s;
    logic [CW-1:0]  cnt_a_r, cnt_a_nxt_s, cnt_b_r, cnt_b_nxt_s;
    logic [1:0]     op_r, op_nxt_s, op_sel_s;
    logic           req_r, req_nxt_s, clear_s;
    logic           is_digit_s, is_op_s, is_bksp_s;

    // Two-flop synchroniser for the scanner level and code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_s1_r <= 1'b0;
            key_valid_s2_r <= 1'b0;
            key_code_s1_r  <= 4'd0;
            key_code_s2_r  <= 4'd0;
        end else begin
            key_valid_s1_r <= key_valid;
            key_valid_s2_r <= key_valid_s1_r;
            key_code_s1_r  <= key_code;
            key_code_s2_r  <= key_code_s1_r;
        end
    end

    // Debounce: the level must disagree for DEB_CYCLES consecutive cycles to flip
    always_comb begin
        deb_nxt_s     = deb_r;
        deb_cnt_nxt_s = deb_cnt_r;
        press_s       = 1'b0;
        if (key_valid_s2_r != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_nxt_s     = key_valid_s2_r;
                deb_cnt_nxt_s = {DCW{1'b0}};
                press_s       = key_valid_s2_r;
            end else begin
                deb_cnt_nxt_s = deb_cnt_r + DCW'(1'b1);
            end
        end else begin
            deb_cnt_nxt_s = {DCW{1'b0}};
        end
    end

    // Debounce state and key event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r      <= 1'b0;
            deb_cnt_r  <= {DCW{1'b0}};
            key_evt_r  <= 1'b0;
            key_last_r <= 4'd0;
        end else begin
            deb_r     <= deb_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            key_evt_r <= press_s;
            if (press_s) begin
                key_last_r <= key_code_s2_r;
            end else begin
                key_last_r <= key_last_r;
            end
        end
    end

    assign is_digit_s = (key_code_s2_r <= 4'd9);
    assign is_op_s    = (key_code_s2_r >= 4'd10) && (key_code_s2_r <= 4'd13);
    assign is_bksp_s  = (key_code_s2_r == 4'd14);
    // code-10 for codes 10..13 equals the low two bits plus 2, modulo 4
    assign op_sel_s   = key_code_s2_r[1:0] + 2'd2;

    // Operand assembly FSM: next state and datapath
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        cnt_a_nxt_s = cnt_a_r;
        cnt_b_nxt_s = cnt_b_r;
        op_nxt_s    = op_r;
        req_nxt_s   = req_r;
        clear_s     = 1'b0;
        case (state_r)
            S_A: begin
                if (press_s) begin
                    if (is_digit_s) begin
                        if (cnt_a_r < CNT_MAX) begin
                            a_nxt_s     = append_digit(a_r, key_code_s2_r);
                            cnt_a_nxt_s = cnt_a_r + CW'(1'b1);
                        end else begin
                            a_nxt_s = a_r;
                        end
                    end else if (is_op_s) begin
                        op_nxt_s    = op_sel_s;
                        state_nxt_s = S_B;
                    end else if (is_bksp_s) begin
`ifdef ENTRY_BACKSPACE_EN
                        if (cnt_a_r != {CW{1'b0}}) begin
                            a_nxt_s     = drop_digit(a_r);
                            cnt_a_nxt_s = cnt_a_r - CW'(1'b1);
                        end else begin
                            a_nxt_s = a_r;
                        end
`else
                        clear_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = S_A;
                    end
                end else begin
                    state_nxt_s = S_A;
                end
            end
            S_B: begin
                if (press_s) begin
                    if (is_digit_s) begin
                        if (cnt_b_r < CNT_MAX) begin
                            b_nxt_s     = append_digit(b_r, key_code_s2_r);
                            cnt_b_nxt_s = cnt_b_r + CW'(1'b1);
                        end else begin
                            b_nxt_s = b_r;
                        end
                    end else if (is_op_s) begin
                        if (cnt_b_r == {CW{1'b0}}) begin
                            op_nxt_s = op_sel_s;
                        end else begin
                            op_nxt_s = op_r;
                        end
                    end else if (is_bksp_s) begin
`ifdef ENTRY_BACKSPACE_EN
                        if (cnt_b_r != {CW{1'b0}}) begin
                            b_nxt_s     = drop_digit(b_r);
                            cnt_b_nxt_s = cnt_b_r - CW'(1'b1);
                        end else begin
                            op_nxt_s    = 2'b00;
                            state_nxt_s = S_A;
                        end
`else
                        clear_s = 1'b1;
`endif
                    end else begin
                        if (cnt_b_r != {CW{1'b0}}) begin
                            req_nxt_s   = 1'b1;
                            state_nxt_s = S_REQ;
                        end else begin
                            req_nxt_s = 1'b0;
                        end
                    end
                end else begin
                    state_nxt_s = S_B;
                end
            end
            S_REQ: begin
                // ack takes priority; any key arriving here is dropped
                if (ack) begin
                    clear_s = 1'b1;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            default: begin
                clear_s = 1'b1;
            end
        endcase
        disp_nxt_s = (state_nxt_s == S_A) ? a_nxt_s : b_nxt_s;
    end

    // Operand, operator, handshake and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_A;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            cnt_a_r <= {CW{1'b0}};
            cnt_b_r <= {CW{1'b0}};
            op_r    <= 2'b00;
            req_r   <= 1'b0;
            disp_r  <= {W{1'b0}};
        end else if (clear_s) begin
            state_r <= S_A;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            cnt_a_r <= {CW{1'b0}};
            cnt_b_r <= {CW{1'b0}};
            op_r    <= 2'b00;
            req_r   <= 1'b0;
            disp_r  <= {W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            cnt_a_r <= cnt_a_nxt_s;
            cnt_b_r <= cnt_b_nxt_s;
            op_r    <= op_nxt_s;
            req_r   <= req_nxt_s;
            disp_r  <= disp_nxt_s;
        end
    end

    assign req       = req_r;
    assign operand_a = a_r;
    assign operand_b = b_r;
    assign op_code   = op_r;
    assign disp_val  = disp_r;
    assign key_evt   = key_evt_r;
    assign key_last  = key_last_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus randomized key traffic,
// all compared every cycle against a behavioural model of the entry rules.
module tb_keypad_entry;
    localparam int W    = 14;
    localparam int MAXD = 4;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   key_code = 4'd0;
    logic         key_valid = 1'b0;
    logic         ack = 1'b0;
    logic         req;
    logic [W-1:0] operand_a, operand_b, disp_val;
    logic [1:0]   op_code;
    logic         key_evt;
    logic [3:0]   key_last;

    always #5 clk = ~clk;

    keypad_entry #(.W(W), .MAX_DIGITS(MAXD), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid), .ack(ack),
        .req(req), .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
        .disp_val(disp_val), .key_evt(key_evt), .key_last(key_last)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int evt_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw input history, debounced level, entry state
    int raw_v[$];
    int raw_c[$];
    int seen[$];
    int m_deb, m_evt, m_last, m_phase, m_a, m_b, m_na, m_nb, m_op, m_req;

    task automatic model_clear();
        m_phase = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_req = 0;
    endtask

    task automatic model_reset();
        raw_v.delete(); raw_c.delete(); seen.delete();
        m_deb = 0; m_evt = 0; m_last = 0;
        model_clear();
    endtask

    task automatic model_apply(input int code);
        if (code <= 9) begin
            if (m_phase == 0 && m_na < MAXD) begin
                m_a = (m_a * 10 + code) % (1 << W); m_na++;
            end else if (m_phase == 1 && m_nb < MAXD) begin
                m_b = (m_b * 10 + code) % (1 << W); m_nb++;
            end
        end else if (code <= 13) begin
            if (m_phase == 0) begin
                m_op = code - 10; m_phase = 1;
            end else if (m_nb == 0) begin
                m_op = code - 10;
            end
        end else if (code == 14) begin
`ifdef ENTRY_BACKSPACE_EN
            if (m_phase == 0) begin
                if (m_na > 0) begin m_a = m_a / 10; m_na--; end
            end else if (m_nb > 0) begin
                m_b = m_b / 10; m_nb--;
            end else begin
                m_op = 0; m_phase = 0;
            end
`else
            model_clear();
`endif
        end else begin
            if (m_phase == 1 && m_nb >= 1) begin m_req = 1; m_phase = 2; end
        end
    endtask

    task automatic model_edge(input int v, input int c, input int a);
        int s_v, s_c, all_diff;
        raw_v.push_back(v); raw_c.push_back(c);
        if (raw_v.size() > 3) begin void'(raw_v.pop_front()); void'(raw_c.pop_front()); end
        // level seen by the debouncer is the input from two edges earlier
        s_v = (raw_v.size() == 3) ? raw_v[0] : 0;
        s_c = (raw_c.size() == 3) ? raw_c[0] : 0;
        m_evt = 0;
        seen.push_back(s_v);
        if (seen.size() > DEB) void'(seen.pop_front());
        if (seen.size() == DEB) begin
            all_diff = 1;
            foreach (seen[i]) if (seen[i] == m_deb) all_diff = 0;
            if (all_diff == 1) begin
                m_deb = 1 - m_deb;
                seen.delete();
                if (m_deb == 1) begin m_evt = 1; m_last = s_c; end
            end
        end
        if (m_phase == 2) begin
            if (a != 0) model_clear();
        end else if (m_evt == 1) begin
            model_apply(s_c);
        end
    endtask

    // Compare process: update model at each edge, check all outputs at the falling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_edge(int'(key_valid), int'(key_code), int'(ack));
            else model_reset();
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("req", int'(req), m_req);
            chk("operand_a", int'(operand_a), m_a);
            chk("operand_b", int'(operand_b), m_b);
            chk("op_code", int'(op_code), m_op);
            chk("disp_val", int'(disp_val), (m_phase == 0) ? m_a : m_b);
            chk("key_evt", int'(key_evt), m_evt);
            chk("key_last", int'(key_last), m_last);
            if (key_evt) evt_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int code);
        key_code = 4'(code); key_valid = 1'b1;
        cyc(8);
        key_valid = 1'b0;
        cyc(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    initial begin
        int e0, r, code;
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_req", int'(req), 0);
        chk("rst_disp", int'(disp_val), 0);
        rst_n = 1'b1;
        cyc(2);

        // 1: bouncing key yields one event
        e0 = evt_seen;
        key_code = 4'd5;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1; cyc(2);
            key_valid = 1'b0; cyc(2);
        end
        key_valid = 1'b1;
        cyc(10);
        chk("t1_evt_count", evt_seen - e0, 1);
        chk("t1_key_last", int'(key_last), 5);
        chk("t1_disp", int'(disp_val), 5);
        key_valid = 1'b0;
        cyc(8);

        // 2: 12 + 3 with delayed ack
        do_reset();
        press(1); press(2); press(10); press(3); press(15);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("t2_req_held", int'(req), 1);
        end
        chk("t2_a", int'(operand_a), 12);
        chk("t2_b", int'(operand_b), 3);
        chk("t2_op", int'(op_code), 0);
        chk("t2_disp", int'(disp_val), 3);
        ack_pulse();
        chk("t2_req_after_ack", int'(req), 0);
        chk("t2_a_after_ack", int'(operand_a), 0);
        chk("t2_b_after_ack", int'(operand_b), 0);
        chk("t2_disp_after_ack", int'(disp_val), 0);

        // 3: fifth digit ignored
        do_reset();
        press(9); press(9); press(9); press(9); press(7);
        chk("t3_a", int'(operand_a), 9999);
        chk("t3_disp", int'(disp_val), 9999);

        // 4: '=' ignored in S_A and with empty b; op replaced
        do_reset();
        press(15); press(7); press(10); press(12); press(15);
        chk("t4_op", int'(op_code), 2);
        chk("t4_req_low", int'(req), 0);
        chk("t4_a", int'(operand_a), 7);
        press(2); press(15);
        chk("t4_req", int'(req), 1);
        chk("t4_b", int'(operand_b), 2);
        ack_pulse();

        // 5: key 14
        do_reset();
`ifdef ENTRY_BACKSPACE_EN
        press(4); press(2); press(14);
        chk("t5_bksp_a", int'(operand_a), 4);
        press(10); press(14);
        chk("t5_back_a", int'(operand_a), 4);
        chk("t5_back_op", int'(op_code), 0);
        chk("t5_back_disp", int'(disp_val), 4);
`else
        press(4); press(2); press(10); press(14);
        chk("t5_clr_a", int'(operand_a), 0);
        chk("t5_clr_op", int'(op_code), 0);
        chk("t5_clr_disp", int'(disp_val), 0);
`endif

        // 6: reset during S_REQ with a key held
        do_reset();
        press(1); press(10); press(2); press(15);
        chk("t6_req", int'(req), 1);
        key_code = 4'd3; key_valid = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", int'(req), 0);
        chk("t6_rst_a", int'(operand_a), 0);
        chk("t6_rst_b", int'(operand_b), 0);
        chk("t6_rst_disp", int'(disp_val), 0);
        chk("t6_rst_last", int'(key_last), 0);
        cyc(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t6_evt_latency", int'(key_evt), (i == 6) ? 1 : 0);
        end
        key_valid = 1'b0;
        cyc(8);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 15) begin
                key_code = 4'($urandom_range(0, 15));
                key_valid = 1'b1;
                cyc($urandom_range(1, 3));
                key_valid = 1'b0;
                cyc($urandom_range(1, 3));
            end else if (r < 27) begin
                ack = 1'b1;
                cyc($urandom_range(1, 2));
                ack = 1'b0;
                cyc(1);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 50) code = $urandom_range(0, 9);
                else if (r < 70) code = $urandom_range(10, 13);
                else if (r < 78) code = 14;
                else code = 15;
                key_code = 4'(code);
                key_valid = 1'b1;
                ack = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
                cyc($urandom_range(4, 9));
                ack = 1'b0;
                key_valid = 1'b0;
                cyc($urandom_range(4, 9));
            end
        end

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
